rr_arbiter32: RTL and testbench
===============================

RR_ARBITER32 -- requirements
Module: rr_arbiter32

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in cycles; 0 means unlimited.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port req, input, 32 bits: bit i high means requester i wants the shared 32:1 mux.
REQ-005 SHALL have port done, input, 1 bit: the current owner releases at the end of this cycle.
REQ-006 SHALL have port grant, output, 32 bits: one-hot owner indication; all zero when no owner.
REQ-007 SHALL have port valid, output, 1 bit: high while a grant is active.
REQ-008 SHALL have port port, output, 5 bits: mux select, equal to the owner index while valid is high.

Function
REQ-009 SHALL implement a two-state FSM: IDLE and OWNED.
REQ-010 In IDLE with req nonzero, SHALL select the first set req bit at or above ptr, wrapping 31->0, and enter OWNED next cycle.
REQ-011 SHALL register grant, port and valid, so the latency from req to grant is exactly 1 cycle from IDLE.
REQ-012 In IDLE with req all zero, SHALL remain in IDLE with valid=0 and grant=0.
REQ-013 In OWNED, SHALL hold grant, port and valid stable until a release event occurs.
REQ-014 Release event SHALL be any of: done=1, req[owner]=0, or hold_cnt reaching MAX_HOLD-1 when MAX_HOLD is nonzero.
REQ-015 On release, SHALL set ptr to (owner+1) mod 32, clear grant and valid, and return to IDLE next cycle.
REQ-016 After every release, SHALL spend exactly one IDLE bubble cycle before the next grant.
REQ-017 Simultaneous release causes in the same cycle SHALL count as one release.
REQ-018 hold_cnt SHALL clear on entry to OWNED and increment each OWNED cycle; it SHALL saturate rather than wrap when MAX_HOLD=0.
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL ignore changes to non-owner req bits while in OWNED.
REQ-021 While valid=0, port SHALL retain the last owner index; only grant and valid indicate ownership.
REQ-022 grant SHALL equal the one-hot decode of port whenever valid=1, and SHALL never have more than one bit set.
REQ-023 A forced release (MAX_HOLD expiry) with req[owner] still high SHALL NOT re-grant that owner if any other req bit is set.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, ptr=0, hold_cnt=0, grant=0, valid=0, port=0, without waiting for a clock edge.
REQ-025 Reset asserted during OWNED SHALL drop the grant asynchronously and discard the owner.
REQ-026 After reset deassertion, the first arbitration SHALL start from ptr=0.

Structure
REQ-027 Shared package arb_pkg SHALL hold: NUM_REQ=32, SEL_W=5, and the state enum typedef (IDLE, OWNED).
REQ-028 Rotating find-first SHALL be a combinational sub-module rr_pick32 with inputs req[32] and ptr[5], and outputs hit and idx[5].
REQ-029 port SHALL connect directly to the 5-bit select of the existing 32:1 mux; this block contains no datapath.

Verification
REQ-030 Reset then req=32'h0000_0001 held: cycle 1 shows valid=1, port=0, grant=32'h1; port and grant hold until done.
REQ-031 req=32'h8000_0001, ptr=0: grant order is port 0, bubble, port 31, bubble, port 0, with done pulsed each tenure.
REQ-032 Wrap-around: after owner 31 releases with req=32'hFFFF_FFFF, the next grant is port 0.
REQ-033 MAX_HOLD=4, req=32'h0000_0006 with no done: port 1 held exactly 4 cycles, one bubble, then port 2.
REQ-034 done=1 and req[owner]=0 in the same cycle: exactly one release, one bubble, and ptr advances by one.
REQ-035 reset_n pulsed low mid-OWNED (owner 7): grant=0 and valid=0 before the next edge; the first post-reset grant uses ptr=0.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared sizes, state type and select decode for the 32-way arbiter
package arb_pkg;

  localparam int NUM_REQ = 32;
  localparam int SEL_W   = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick32.sv
// rtl/rr_pick32.sv - rotating find-first: lowest set req bit at or above ptr, wrapping 31->0
module rr_pick32
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               hit,
  output logic [SEL_W-1:0]   idx
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    logic             found;
    hit   = |req;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    // Candidate index wraps naturally in SEL_W bits.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter32.sv
// rtl/rr_arbiter32.sv - round-robin owner arbiter driving the select of a shared 32:1 mux
module rr_arbiter32
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid,
  output logic [SEL_W-1:0]   port
);

  // Unlimited tenure keeps a modest saturating counter that never triggers release.
  localparam int HOLD_W = (MAX_HOLD < 2) ? 8 : $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  arb_state_t         state, state_d;
  logic [SEL_W-1:0]   ptr, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               valid_d;
  logic [SEL_W-1:0]   port_d;

  logic               pick_hit;
  logic [SEL_W-1:0]   pick_idx;
  logic               expired;
  logic               release_evt;

  rr_pick32 u_pick (
    .req (req),
    .ptr (ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  assign expired     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_evt = done || !req[port] || expired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      valid    <= 1'b0;
      port     <= '0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      hold_cnt <= hold_cnt_d;
      grant    <= grant_d;
      valid    <= valid_d;
      port     <= port_d;
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    hold_cnt_d = hold_cnt;
    grant_d    = grant;
    valid_d    = valid;
    port_d     = port;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          state_d    = OWNED;
          port_d     = pick_idx;
          valid_d    = 1'b1;
          grant_d    = sel_decode(pick_idx);
          hold_cnt_d = '0;
        end
      end
      OWNED: begin
        // port is kept after release so the mux select stays quiet while idle.
        if (release_evt) begin
          state_d = IDLE;
          ptr_d   = port + SEL_W'(1);
          valid_d = 1'b0;
          grant_d = '0;
        end else if (hold_cnt != '1) begin
          hold_cnt_d = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter32.sv
// tb/tb_rr_arbiter32.sv - directed and random checks of rr_arbiter32 against a tenure-level model
module tb_rr_arbiter32;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] req;
  logic        done;
  logic [31:0] grant;
  logic        valid;
  logic [4:0]  port;

  always #5 clk = ~clk;

  rr_arbiter32 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .valid   (valid),
    .port    (port)
  );

  int total = 0;
  int bad   = 0;

  // Model: who owns the mux, how many cycles they have had it, where the next search starts.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_last  = 0;
  endtask

  task automatic model_clock(input logic [31:0] r, input logic d);
    if (m_owner < 0) begin
      for (int k = 0; k < 32; k++) begin
        int c;
        c = (m_ptr + k) % 32;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 0;
          break;
        end
      end
    end else if (d || !r[m_owner] || (MH != 0 && m_held + 1 >= MH)) begin
      m_ptr   = (m_owner + 1) % 32;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] exp_grant;
    exp_grant = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    chk("valid", {31'b0, valid}, {31'b0, (m_owner >= 0)});
    chk("port", {27'b0, port}, 32'(m_last));
    chk("grant", grant, exp_grant);
    chk("onehot", {31'b0, ($countones(grant) <= 1)}, 32'h1);
  endtask

  task automatic step(input logic [31:0] r, input logic d);
    @(negedge clk);
    check_outputs();
    req  = r;
    done = d;
    model_clock(r, d);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] prev;
    logic        d;

    reset_n = 1'b1;
    req     = '0;
    done    = 1'b0;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant", grant, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_port", {27'b0, port}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single requester, one-cycle latency, then done.
    repeat (3) step(32'h0000_0001, 1'b0);
    step(32'h0000_0001, 1'b1);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    // Alternation between ports 0 and 31 with a bubble between tenures.
    r = 32'h8000_0001;
    repeat (3) begin
      step(r, 1'b0);
      step(r, 1'b1);
    end
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    // Wrap-around from owner 31 to port 0.
    step(32'h8000_0000, 1'b0);
    step(32'hFFFF_FFFF, 1'b1);
    step(32'hFFFF_FFFF, 1'b0);
    step(32'hFFFF_FFFF, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    // Tenure expiry: ports 1 and 2 alternate every MH cycles.
    repeat (14) step(32'h0000_0006, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    // done and owner request drop together count once.
    step(32'h0000_0030, 1'b0);
    step(32'h0000_0030, 1'b0);
    step(32'h0000_0020, 1'b1);
    step(32'h0000_0030, 1'b0);
    step(32'h0000_0030, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    // Asynchronous reset while owner 7 holds the grant.
    step(32'h0000_0080, 1'b0);
    step(32'h0000_0080, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_grant", grant, 32'h0);
    chk("arst_valid", {31'b0, valid}, 32'h0);
    chk("arst_port", {27'b0, port}, 32'h0);
    req  = '0;
    done = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(32'h8000_0081, 1'b0);
    step(32'h8000_0081, 1'b1);
    step(32'h0, 1'b0);

    // Random traffic.
    prev = 32'h0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: r = prev;
        1: r = $urandom & $urandom & $urandom;
        2: r = prev | (32'h1 << $urandom_range(0, 31));
        default: r = $urandom;
      endcase
      d = ($urandom_range(0, 4) == 0);
      step(r, d);
      prev = r;
    end
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);
    step(32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
